// File: rtl/trojan9_pipe.sv
// trojan9_pipe: three-stage pipelined four-mode arithmetic core.
//
// Computes one of four results from operands a..e, selected per transaction
// by mode, through a registered S1 -> S2 -> S3 datapath. A single global
// enable (adv) moves every stage forward together, so bubbles are carried
// through rather than collapsed.
//
// Ports:
//   clk        clock, rising-edge
//   rst        synchronous active-high reset
//   in_valid   operand/mode set valid
//   in_ready   block accepts the operand set this cycle (= adv)
//   a..e       operands, INPUT_WIDTH bits each
//   mode       00=m1 01=m2 10=m3 11=m4
//   out_valid  y valid
//   out_ready  consumer accepts y this cycle
//   y          selected result, 2*INPUT_WIDTH bits
//   txn_count  results consumed, modulo 2^COUNT_WIDTH
//   ovf        overflow flag, valid with out_valid (only with TROJAN9_PIPE_OVF_EN)
//
// Optional feature macro: TROJAN9_PIPE_OVF_EN adds the ovf output.

module trojan9_pipe #(
  parameter int                     INPUT_WIDTH = 8,
  parameter logic [INPUT_WIDTH-1:0] MASK1       = INPUT_WIDTH'(8'h0F),
  parameter int                     SHIFT       = 2,
  parameter int                     COUNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INPUT_WIDTH-1:0]   a,
  input  logic [INPUT_WIDTH-1:0]   b,
  input  logic [INPUT_WIDTH-1:0]   c,
  input  logic [INPUT_WIDTH-1:0]   d,
  input  logic [INPUT_WIDTH-1:0]   e,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*INPUT_WIDTH-1:0] y,
  output logic [COUNT_WIDTH-1:0]   txn_count
`ifdef TROJAN9_PIPE_OVF_EN
  ,
  output logic                     ovf
`endif
);

  localparam int W   = INPUT_WIDTH;
  localparam int RW  = 2 * INPUT_WIDTH;
  localparam int RW1 = RW + 1;
  localparam int RW2 = RW + 2;

  logic adv;

  // S1 registers
  logic         s1_v;
  logic [W:0]   s1_sab, s1_scd, s1_sxd;
  logic [W-1:0] s1_a, s1_b, s1_c, s1_d, s1_em;
  logic [1:0]   s1_mode;

  // S2 registers
  logic          s2_v;
  logic [RW-1:0] s2_m1, s2_m2, s2_m3;
  logic [1:0]    s2_mode;

  // S2 next-state arithmetic
  logic [RW-1:0] m1_nxt, m2_nxt, m3_nxt;
  logic [RW-1:0] y_nxt;

`ifdef TROJAN9_PIPE_OVF_EN
  logic [RW2-1:0] m1_full;
  logic [RW1-1:0] m2_full;
  logic           s2_ovf1, s2_ovf2;
  logic           ovf_nxt;
`endif

  // Stall only when a result is waiting and the consumer refuses it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef TROJAN9_PIPE_OVF_EN
  // Full-precision products so the bits above 2W are available for ovf.
  assign m1_full = RW2'(s1_sab) * RW2'(s1_scd);
  assign m2_full = RW1'(s1_a) * RW1'(s1_c) + RW1'(s1_b) * RW1'(s1_d);
  assign m1_nxt  = m1_full[RW-1:0];
  assign m2_nxt  = m2_full[RW-1:0];
`else
  assign m1_nxt  = RW'(s1_sab) * RW'(s1_scd);
  assign m2_nxt  = RW'(s1_a) * RW'(s1_c) + RW'(s1_b) * RW'(s1_d);
`endif
  assign m3_nxt  = RW'(s1_sxd) * RW'(s1_em);

  always_comb begin
    y_nxt = s2_m1;
    unique case (s2_mode)
      2'b00: y_nxt = s2_m1;
      2'b01: y_nxt = s2_m2;
      2'b10: y_nxt = s2_m3;
      2'b11: y_nxt = (s2_m1 + s2_m2) ^ (s2_m3 >> SHIFT);
      default: y_nxt = s2_m1;
    endcase
  end

`ifdef TROJAN9_PIPE_OVF_EN
  always_comb begin
    ovf_nxt = 1'b0;
    unique case (s2_mode)
      2'b00, 2'b11: ovf_nxt = s2_ovf1;
      2'b01:        ovf_nxt = s2_ovf2;
      default:      ovf_nxt = 1'b0;
    endcase
  end
`endif

  // Control state and y: reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      txn_count <= '0;
`ifdef TROJAN9_PIPE_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready)
        txn_count <= txn_count + COUNT_WIDTH'(1);
      if (adv) begin
        s1_v      <= in_valid;
        s2_v      <= s1_v;
        out_valid <= s2_v;
        // A bubble entering S3 leaves y at its last delivered value.
        if (s2_v) begin
          y   <= y_nxt;
`ifdef TROJAN9_PIPE_OVF_EN
          ovf <= ovf_nxt;
`endif
        end
      end
    end
  end

  // Datapath registers need no reset; their contents are only ever used
  // alongside a set valid bit.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sab  <= {1'b0, a} + {1'b0, b};
      s1_scd  <= {1'b0, c} + {1'b0, d};
      s1_sxd  <= {1'b0, a ^ b} + {1'b0, d};
      s1_a    <= a;
      s1_b    <= b;
      s1_c    <= c;
      s1_d    <= d;
      s1_em   <= e & MASK1;
      s1_mode <= mode;
      s2_m1   <= m1_nxt;
      s2_m2   <= m2_nxt;
      s2_m3   <= m3_nxt;
      s2_mode <= s1_mode;
`ifdef TROJAN9_PIPE_OVF_EN
      s2_ovf1 <= |m1_full[RW2-1:RW];
      s2_ovf2 <= m2_full[RW];
`endif
    end
  end

endmodule

// File: doc/trojan9_pipe.md
Name: trojan9_pipe

Overview:
Pipelined, parametrised successor to the combinational four-mode arithmetic core.
- Operates on five operands and computes one of four arithmetic results selected by a per-transaction mode.
- Three-stage registered datapath with valid/ready handshakes on input and output.
- Adds configurable mask and shift, a completed-transaction counter, and optional overflow reporting.
- Sits between an operand source and a result consumer in the trojan_core datapath.

Parameters:
- INPUT_WIDTH, 8, operand width W; result width is 2W.
- MASK1, 8'h0F (INPUT_WIDTH bits), mask ANDed with e in mode 2.
- SHIFT, 2, right-shift amount applied to m3 in mode 3; legal range 0..2W-1.
- COUNT_WIDTH, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/mode set is valid.
- in_ready  output  1  block accepts the operand set this cycle.
- a, b, c, d, e  input  W each  operands.
- mode  input  2  00=m1, 01=m2, 10=m3, 11=m4.
- out_valid  output  1  y is valid.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  2W  selected result.
- txn_count  output  COUNT_WIDTH  number of results consumed, modulo 2^COUNT_WIDTH.

Behaviour:
- Arithmetic (all sums and products modulo 2^(2W)):
  - m1 = (a+b)*(c+d); the sums are W+1 bits wide.
  - m2 = a*c + b*d.
  - m3 = ((a^b)+d) * (e & MASK1).
  - m4 = (m1+m2) ^ (m3 >> SHIFT), logical shift.
- Pipeline:
  - S1 registers a+b, c+d, a, b, c, d, (a^b)+d, e&MASK1 and mode.
  - S2 registers m1, m2 and m3.
  - S3 registers the muxed y.
  - Each stage carries a valid bit.
- Flow control uses a global enable: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=1, every stage shifts forward one position, and S1 captures the inputs with valid = in_valid.
  - When adv=0, all stage registers hold.
  - Bubbles are carried, not collapsed.
- Handshake:
  - A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
  - Latency from transfer in to out_valid is exactly 3 cycles with out_ready held high.
  - Throughput is 1 result per cycle.
- While out_valid=1 and out_ready=0, y and out_valid hold stable.
- Mode is captured with the operands; a mode change on the input never affects in-flight transactions.
- Inputs presented while in_ready=0 are ignored. The source must hold them until accepted, and the block does not check this.
- txn_count increments by 1 on each transfer out and wraps from all-ones to 0.
- Reset:
  - All valid bits and txn_count clear to 0; y clears to 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset asserted mid-operation discards all in-flight transactions, with no output for them.
  - rst has priority over every other event in the same cycle.
- Data registers other than y may skip reset. They must never be observable while out_valid=0, except that y retains its last value.

Optional Feature:
- Macro: TROJAN9_PIPE_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), valid with out_valid.
  - For modes 00 and 11, ovf = 1 when the full-precision (2W+2-bit) m1 product has either of its upper two bits set.
  - For mode 01, ovf = 1 when the carry out of a*c + b*d is set.
  - For mode 10, ovf = 0.
  - ovf resets to 0 and holds with y under backpressure.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
Default parameters (W=8, MASK1=0x0F, SHIFT=2) unless noted.
- Mode sweep: a=3, b=5, c=2, d=4, e=0xFF, out_ready=1, modes 00/01/10/11 back-to-back on consecutive cycles.
  - Required y, on consecutive cycles starting 3 cycles after the first accept: 0x0030, 0x001A, 0x0096, 0x006F.
  - txn_count ends at 4.
- Truncation: a=b=c=d=0xFF, mode=00.
  - Required: y=0xF804.
  - With TROJAN9_PIPE_OVF_EN: ovf=1.
  - With a=b=c=d=1: y=0x0004 and ovf=0.
- Backpressure: issue 3 transactions (mode sweep values), then drop out_ready for 5 cycles.
  - in_ready=0 and y=0x0030 stable throughout.
  - Raise out_ready: 0x0030, 0x001A, 0x0096 delivered in order, no loss or duplication.
- Bubbles: in_valid toggles 1,0,1 with out_ready=1.
  - out_valid pattern 1,0,1 starting 3 cycles after the first accept.
  - txn_count=2.
- Reset mid-flight: accept 2 transactions, assert rst for 1 cycle before either emerges.
  - out_valid stays 0 thereafter, y=0, txn_count=0, in_ready=1 the cycle after reset.
- Wrap: COUNT_WIDTH=2, complete 5 transactions → txn_count sequence 1, 2, 3, 0, 1.
